// File: rtl/spwm_demod.sv
// spwm_demod: rebuilds the three modulating references of an SPWM inverter by timing each
//   upper gate's on-time over one carrier window (optional leg fault monitor: SPWM_DEMOD_FAULT_EN).
//   Latency: 2-clock input sync; results load one clock after the window's terminal cycle.
//   Backpressure: none; valid is a one-clock strobe and xd/yd/zd hold between strobes.
module spwm_demod #(
  parameter int N      = 32,
  parameter int Q      = 28,
  parameter int PERIOD = 20000,
  parameter int K      = 26844,
  parameter int DT     = 8
) (
  input  logic                clk,
  input  logic                res,
  input  logic                Sau,
  input  logic                Sal,
  input  logic                Sbu,
  input  logic                Sbl,
  input  logic                Scu,
  input  logic                Scl,
  input  logic                sync,
  input  logic                fault_clr,
  output logic signed [N-1:0] xd,
  output logic signed [N-1:0] yd,
  output logic signed [N-1:0] zd,
  output logic                valid,
  output logic [2:0]          fault
);

  // Counters must be able to hold a full window of highs (h = PERIOD).
  localparam int CW = $clog2(PERIOD + 1);
  // Product width: counter bits + N, plus a sign bit so h*K never wraps.
  localparam int PW = CW + N + 1;

  localparam logic [CW-1:0]        TERM    = CW'(PERIOD - 1);
  localparam logic signed [PW-1:0] ONE     = PW'(1) <<< Q;
  localparam logic signed [PW-1:0] NEG_ONE = -ONE;
  localparam logic signed [PW-1:0] KW      = PW'(K);
  localparam logic [N-1:0]         REF_MIN = NEG_ONE[N-1:0];

  // Synchronized upper gate copies, bit0 = a, bit1 = b, bit2 = c.
  logic [2:0] up_m_q, up_s_q;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0][CW-1:0] hcnt_q, hcnt_d;
  logic [2:0][CW-1:0] hold_q, hold_d;
  logic               lat_q, lat_d;
  logic               term;

  logic [2:0][N-1:0]  ref_q, ref_d;
  logic               valid_q, valid_d;

  // Map an on-time count to Q format: h*K - 1.0, clamped to [-1.0, +1.0].
  function automatic logic [N-1:0] to_ref(input logic [CW-1:0] h);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] diff;
    prod = $signed({{(PW-CW){1'b0}}, h}) * KW;
    diff = prod - ONE;
    if (diff > ONE) begin
      diff = ONE;
    end else if (diff < NEG_ONE) begin
      diff = NEG_ONE;
    end
    return diff[N-1:0];
  endfunction

  // Two-flop synchronizer on the upper gate signals.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      up_m_q <= '0;
      up_s_q <= '0;
    end else begin
      up_m_q <= {Scu, Sbu, Sau};
      up_s_q <= up_m_q;
    end
  end

  assign term = (cnt_q == TERM);

  // Window counter and per-phase on-time counters; sync beats the terminal latch.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    hcnt_d = hcnt_q;
    hold_d = hold_q;
    lat_d  = 1'b0;
    if (sync) begin
      cnt_d  = '0;
      hcnt_d = '0;
    end else if (term) begin
      cnt_d = '0;
      lat_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
        // The terminal cycle's own sample belongs to the closing window.
        hold_d[i] = hcnt_q[i] + CW'(up_s_q[i]);
        hcnt_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        hcnt_d[i] = hcnt_q[i] + CW'(up_s_q[i]);
      end
    end
  end

  // Window state registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q  <= '0;
      hcnt_q <= '0;
      hold_q <= '0;
      lat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
      lat_q  <= lat_d;
    end
  end

  // Output stage: a latch scheduled last edge always produces its strobe, even under sync.
  always_comb begin
    ref_d   = ref_q;
    valid_d = lat_q;
    if (lat_q) begin
      for (int i = 0; i < 3; i++) begin
        ref_d[i] = to_ref(hold_q[i]);
      end
    end
  end

  // Output registers; reset parks every reference at -1.0.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < 3; i++) begin
        ref_q[i] <= REF_MIN;
      end
      valid_q <= 1'b0;
    end else begin
      ref_q   <= ref_d;
      valid_q <= valid_d;
    end
  end

  assign xd    = ref_q[0];
  assign yd    = ref_q[1];
  assign zd    = ref_q[2];
  assign valid = valid_q;

`ifdef SPWM_DEMOD_FAULT_EN
  // Run counter saturates just past DT so it never wraps back under the threshold.
  localparam int            RW      = $clog2(DT + 2);
  localparam logic [RW-1:0] RUN_MAX = RW'(DT + 1);
  localparam logic [RW-1:0] RUN_LIM = RW'(DT);

  logic [2:0]          lo_m_q, lo_s_q;
  logic [2:0][RW-1:0]  run_q, run_d;
  logic [2:0]          fault_q, fault_d;
  logic [2:0]          hit;

  // Two-flop synchronizer on the lower gate signals.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      lo_m_q <= '0;
      lo_s_q <= '0;
    end else begin
      lo_m_q <= {Scl, Sbl, Sal};
      lo_s_q <= lo_m_q;
    end
  end

  // Count cycles a leg shows upper == lower; a fresh detection outranks fault_clr.
  always_comb begin
    run_d   = run_q;
    hit     = '0;
    fault_d = fault_q;
    for (int i = 0; i < 3; i++) begin
      if (up_s_q[i] == lo_s_q[i]) begin
        run_d[i] = (run_q[i] == RUN_MAX) ? RUN_MAX : run_q[i] + 1'b1;
      end else begin
        run_d[i] = '0;
      end
      hit[i]     = (run_d[i] > RUN_LIM);
      fault_d[i] = hit[i] | (fault_q[i] & ~fault_clr);
    end
  end

  // Run counters and sticky fault flags.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      run_q   <= '0;
      fault_q <= '0;
    end else begin
      run_q   <= run_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  // Lower gates and fault controls only matter when the fault monitor is built.
  logic unused_lower;
  assign unused_lower = ^{Sal, Sbl, Scl, fault_clr, DT[0]};
  assign fault        = 3'b000;
`endif

endmodule
